// File: rtl/captura_canal.sv
// Per-channel capture memory: waits for a sample above the armed threshold, stores one
// DEPTH-sample window, then serves it through a registered read port.
module captura_canal #(
  parameter int M     = 12,
  parameter int DEPTH = 150
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [M-1:0] adc_data,
  input  logic         adc_valid,
  input  logic [M-1:0] threshold,
  input  logic         arm,
  input  logic [9:0]   dir,
  output logic [M-1:0] data_out,
  output logic         busy,
  output logic         done,
  output logic [7:0]   wr_count
);

  localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [7:0] DEPTH_C = 8'(DEPTH);
  localparam logic [9:0] DEPTH_D = 10'(DEPTH);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

  state_t       state, state_nxt;
  logic [M-1:0] thr;
  logic [M-1:0] mem [DEPTH];
  logic         we;
  logic         thr_ld;
  logic [7:0]   cnt_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    we        = 1'b0;
    thr_ld    = 1'b0;
    cnt_nxt   = wr_count;
    case (state)
      IDLE, DONE: begin
        if (arm) begin
          state_nxt = ARMED;
          thr_ld    = 1'b1;
          cnt_nxt   = 8'd0;
        end
      end
      ARMED: begin
        // strict compare: a sample equal to the level does not trigger
        if (adc_valid && (adc_data > thr)) begin
          we        = 1'b1;
          cnt_nxt   = 8'd1;
          state_nxt = (DEPTH_C == 8'd1) ? DONE : CAPTURE;
        end
      end
      CAPTURE: begin
        if (adc_valid) begin
          we      = 1'b1;
          cnt_nxt = wr_count + 8'd1;
          if (cnt_nxt == DEPTH_C) state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      thr      <= '0;
      wr_count <= 8'd0;
    end else begin
      if (thr_ld) thr <= threshold;
      wr_count <= cnt_nxt;
    end
  end

  // wr_count is 0 in ARMED, so it doubles as the write address in both writing states
  always_ff @(posedge clk) begin
    if (we) mem[wr_count[AW-1:0]] <= adc_data;
  end

  // read-first: a same-edge write is seen on the following read
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                data_out <= '0;
    else if (dir < DEPTH_D)   data_out <= mem[dir[AW-1:0]];
    else                      data_out <= '0;
  end

  assign busy = (state == ARMED) || (state == CAPTURE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_captura_canal.sv
// Directed bench for captura_canal: expected window contents are queued as samples are
// driven and popped during readback.
module tb_captura_canal;

  localparam int M     = 12;
  localparam int DEPTH = 150;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [M-1:0] adc_data = '0;
  logic         adc_valid = 1'b0;
  logic [M-1:0] threshold = '0;
  logic         arm = 1'b0;
  logic [9:0]   dir = '0;
  logic [M-1:0] data_out;
  logic         busy, done;
  logic [7:0]   wr_count;

  int checks = 0;
  int failures = 0;
  logic [M-1:0] exp_q[$];

  captura_canal #(.M(M), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .adc_data(adc_data), .adc_valid(adc_valid),
    .threshold(threshold), .arm(arm), .dir(dir), .data_out(data_out),
    .busy(busy), .done(done), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic feed(input logic [M-1:0] d);
    adc_data  = d;
    adc_valid = 1'b1;
    tick();
    adc_valid = 1'b0;
  endtask

  task automatic arm_pulse(input logic [M-1:0] t);
    threshold = t;
    arm       = 1'b1;
    tick();
    arm       = 1'b0;
  endtask

  task automatic readback(input string tag);
    logic [M-1:0] e;
    for (int k = 0; k < DEPTH; k++) begin
      dir = 10'(k);
      tick();
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL %s_underflow observed=%0d expected=queued", tag, data_out);
      end else begin
        e = exp_q.pop_front();
        chk(tag, 32'(data_out), 32'(e));
      end
    end
  endtask

  initial begin
    // reset state
    #2 reset = 1'b1;
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_cnt", 32'(wr_count), 0);
    chk("rst_dout", 32'(data_out), 0);
    tick();
    reset = 1'b0;
    tick();

    // 1: trigger above thr=100, ramp capture
    arm_pulse(12'd100);
    chk("t1_busy_armed", 32'(busy), 1);
    feed(12'd50);
    feed(12'd100);
    chk("t1_no_trig_eq", 32'(wr_count), 0);
    feed(12'd101);
    exp_q.push_back(12'd101);
    chk("t1_trig_cnt", 32'(wr_count), 1);
    for (int i = 0; i < DEPTH - 2; i++) begin
      feed(12'(102 + i));
      exp_q.push_back(12'(102 + i));
    end
    chk("t1_cnt149", 32'(wr_count), 149);
    chk("t1_busy149", 32'(busy), 1);
    chk("t1_done149", 32'(done), 0);
    feed(12'd250);
    exp_q.push_back(12'd250);
    chk("t1_cnt150", 32'(wr_count), 150);
    chk("t1_busy_end", 32'(busy), 0);
    chk("t1_done_end", 32'(done), 1);
    feed(12'd999);
    chk("t1_no_wr_done", 32'(wr_count), 150);
    readback("t1_rd");

    // 3: out-of-range reads
    dir = 10'd150;
    tick();
    chk("t3_rd150", 32'(data_out), 0);
    dir = 10'd1023;
    tick();
    chk("t3_rd1023", 32'(data_out), 0);

    // 2: valid toggling, invalid cycles carry garbage
    arm_pulse(12'd0);
    for (int i = 0; i < 2 * DEPTH; i++) begin
      adc_valid = (i % 2 == 0);
      adc_data  = (i % 2 == 0) ? 12'(1000 + i / 2) : 12'(3000 + i);
      if (i % 2 == 0) exp_q.push_back(12'(1000 + i / 2));
      tick();
    end
    adc_valid = 1'b0;
    chk("t2_cnt", 32'(wr_count), 150);
    chk("t2_done", 32'(done), 1);
    readback("t2_rd");

    // 5: arm mid-capture ignored
    arm_pulse(12'd0);
    for (int i = 0; i < 10; i++) begin
      feed(12'(2000 + i));
      exp_q.push_back(12'(2000 + i));
    end
    chk("t5_cnt10", 32'(wr_count), 10);
    arm_pulse(12'd4000);
    chk("t5_arm_ign_cnt", 32'(wr_count), 10);
    chk("t5_arm_ign_busy", 32'(busy), 1);
    for (int i = 10; i < DEPTH; i++) begin
      feed(12'(2000 + i));
      exp_q.push_back(12'(2000 + i));
    end
    chk("t5_cnt150", 32'(wr_count), 150);
    chk("t5_done", 32'(done), 1);
    readback("t5_rd");
    arm_pulse(12'd4095);
    chk("t5_rearm_busy", 32'(busy), 1);
    chk("t5_rearm_done", 32'(done), 0);
    chk("t5_rearm_cnt", 32'(wr_count), 0);
    feed(12'd4095);
    feed(12'd4094);
    feed(12'd0);
    chk("t5_never_cnt", 32'(wr_count), 0);
    chk("t5_never_busy", 32'(busy), 1);

    // 4: reset mid-capture
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    arm_pulse(12'd0);
    for (int i = 0; i < 60; i++) feed(12'(500 + i));
    dir = 10'd5;
    tick();
    chk("t4_pre_dout", 32'(data_out), 505);
    chk("t4_cnt60", 32'(wr_count), 60);
    #2 reset = 1'b1;
    #1;
    chk("t4_rst_cnt", 32'(wr_count), 0);
    chk("t4_rst_busy", 32'(busy), 0);
    chk("t4_rst_dout", 32'(data_out), 0);
    tick();
    reset = 1'b0;
    tick();
    arm_pulse(12'd0);
    feed(12'd5);
    chk("t4_new_cnt", 32'(wr_count), 1);
    dir = 10'd0;
    tick();
    chk("t4_rd0", 32'(data_out), 5);
    dir = 10'd60;
    tick();
    chk("t4_rd60_old", 32'(data_out), 2060);

    // 6: read-first on same-edge write to address 1 (holds 501 from aborted window)
    dir       = 10'd1;
    adc_data  = 12'd77;
    adc_valid = 1'b1;
    tick();
    adc_valid = 1'b0;
    chk("t6_read_first", 32'(data_out), 501);
    tick();
    chk("t6_read_new", 32'(data_out), 77);
    chk("t6_cnt", 32'(wr_count), 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
